// File: rtl/pearson_check.sv
// Receive-side Pearson hash checker: recomputes an 8-bit Pearson hash over the
// payload of each frame and compares it with the trailing hash byte.
module pearson_check #(
  parameter int MAX_LEN = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic       done_o,
  output logic       match_o,
  output logic       len_err_o,
  output logic [7:0] hash_o,
  output logic [7:0] len_o
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ACC, REPORT} state_t;

  state_t     state_q, state_d;
  logic [7:0] h_p0, h_d;
  logic [7:0] cnt_p0, cnt_d;
  logic       ovf_p0, ovf_d;
  logic       rep_load;
  logic       accept;

  logic       match_p1, len_err_p1;
  logic [7:0] hash_p1, len_p1;

  // Fixed permutation T[i] = (167*i + 13) mod 256; 167 is odd, so it is a bijection.
  function automatic logic [7:0] pearson_t(input logic [7:0] idx);
    logic [15:0] prod;
    prod = 16'(idx) * 16'd167 + 16'd13;
    return prod[7:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign ready_o = (state_q != REPORT);
  assign done_o  = (state_q == REPORT);
  assign accept  = valid_i & ready_o;

  always_comb begin
    state_d  = state_q;
    h_d      = h_p0;
    cnt_d    = cnt_p0;
    ovf_d    = ovf_p0;
    rep_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (last_i) begin
            rep_load = 1'b1;
            state_d  = REPORT;
          end else begin
            h_d     = pearson_t(data_i);
            cnt_d   = 8'd1;
            ovf_d   = 1'b0;
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept) begin
          if (last_i) begin
            rep_load = 1'b1;
            state_d  = REPORT;
          end else begin
            h_d   = pearson_t(h_p0 ^ data_i);
            cnt_d = sat_inc(cnt_p0);
            if (cnt_p0 == MAX_LEN_B) ovf_d = 1'b1;
          end
        end
      end
      REPORT: begin
        h_d     = 8'd0;
        cnt_d   = 8'd0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: frame accumulation state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      h_p0    <= 8'd0;
      cnt_p0  <= 8'd0;
      ovf_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_p0    <= h_d;
      cnt_p0  <= cnt_d;
      ovf_p0  <= ovf_d;
    end
  end

  // Stage p1: verdict registers, loaded only on the edge entering REPORT
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      match_p1   <= 1'b0;
      len_err_p1 <= 1'b0;
      hash_p1    <= 8'd0;
      len_p1     <= 8'd0;
    end else if (rep_load) begin
      match_p1   <= (data_i == h_p0) & ~ovf_p0;
      len_err_p1 <= ovf_p0;
      hash_p1    <= h_p0;
      len_p1     <= cnt_p0;
    end
  end

  assign match_o   = match_p1;
  assign len_err_o = len_err_p1;
  assign hash_o    = hash_p1;
  assign len_o     = len_p1;

endmodule

// File: tb/tb_pearson_check.sv
// Randomized self-checking bench for pearson_check; two instances (MAX_LEN=4
// and the default 64) share one input stream and are checked against a model.
module tb_pearson_check;

  typedef logic [7:0] bq_t[$];

  logic       clk, reset_i;
  logic [7:0] data_i;
  logic       valid_i, last_i;

  logic       rdy4, done4, m4, e4;
  logic [7:0] h4, l4;
  logic       rdy64, done64, m64, e64;
  logic [7:0] h64, l64;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] prev_h, prev_l;
  logic       prev_m4, prev_e4, prev_m64, prev_e64;
  bit         pending_b2b;

  pearson_check #(.MAX_LEN(4)) u_dut4 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(rdy4), .done_o(done4), .match_o(m4),
    .len_err_o(e4), .hash_o(h4), .len_o(l4)
  );

  pearson_check u_dut64 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(rdy64), .done_o(done64), .match_o(m64),
    .len_err_o(e64), .hash_o(h64), .len_o(l64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pearson hash straight from the definition: h = T[h ^ b] per payload byte.
  function automatic logic [7:0] ref_hash(input bq_t pl);
    int hv;
    hv = 0;
    foreach (pl[i]) hv = (167 * (hv ^ int'(pl[i])) + 13) % 256;
    return 8'(hv);
  endfunction

  // Enters and leaves on a falling edge; the byte transfers on the rising edge between.
  task automatic xfer(input logic [7:0] d, input logic l, output int stalls);
    stalls  = 0;
    data_i  = d;
    last_i  = l;
    valid_i = 1'b1;
    while (!rdy4 && stalls < 4) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 4) chk("ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input bq_t pl, input logic [7:0] hb, input bit b2b);
    int         n, st;
    logic [7:0] eh, el;
    logic       ee4, ee64, em4, em64;
    n    = pl.size();
    eh   = ref_hash(pl);
    el   = (n > 255) ? 8'd255 : 8'(n);
    ee4  = (n > 4);
    ee64 = (n > 64);
    em4  = (hb == eh) && !ee4;
    em64 = (hb == eh) && !ee64;
    for (int i = 0; i < n; i++) begin
      xfer(pl[i], 1'b0, st);
      if (i == 0) chk("stall_first", st, pending_b2b ? 1 : 0);
      if (i < 3) begin
        chk("no_done_mid", {done4, done64}, 2'b00);
        chk("hash_held", {h4, h64}, {prev_h, prev_h});
        chk("verdict_held", {m4, e4, m64, e64, l4},
            {prev_m4, prev_e4, prev_m64, prev_e64, prev_l});
      end
    end
    xfer(hb, 1'b1, st);
    if (n == 0) chk("stall_first", st, pending_b2b ? 1 : 0);
    chk("done", {done4, done64}, 2'b11);
    chk("ready_in_report", {rdy4, rdy64}, 2'b00);
    chk("hash_o", {h4, h64}, {eh, eh});
    chk("len_o", {l4, l64}, {el, el});
    chk("match4", m4, em4);
    chk("len_err4", e4, ee4);
    chk("match64", m64, em64);
    chk("len_err64", e64, ee64);
    prev_h = eh; prev_l = el;
    prev_m4 = em4; prev_e4 = ee4; prev_m64 = em64; prev_e64 = ee64;
    pending_b2b = b2b;
    if (!b2b) begin
      valid_i = 1'b0;
      @(negedge clk);
      chk("done_pulse", {done4, done64}, 2'b00);
      chk("ready_idle", {rdy4, rdy64}, 2'b11);
    end
  endtask

  task automatic rand_frame(input int len, input bit b2b);
    bq_t        pl;
    logic [7:0] hb;
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    hb = ref_hash(pl);
    if ($urandom_range(0, 1) == 0) hb = 8'($urandom);
    run_frame(pl, hb, b2b);
  endtask

  initial begin
    bq_t pl;
    int  st;
    reset_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; data_i = 8'd0;
    prev_h = 0; prev_l = 0; prev_m4 = 0; prev_e4 = 0; prev_m64 = 0; prev_e64 = 0;
    pending_b2b = 0;

    #2 reset_i = 1'b1;
    #1;
    chk("reset_outs4", {done4, m4, e4, h4, l4}, 19'd0);
    chk("reset_outs64", {done64, m64, e64, h64, l64}, 19'd0);
    chk("reset_ready", {rdy4, rdy64}, 2'b11);
    @(negedge clk);
    reset_i = 1'b0;

    run_frame('{8'h00}, 8'h0D, 0);
    run_frame('{8'h01, 8'h02}, 8'hC7, 0);
    run_frame('{8'h01, 8'h02}, 8'hC6, 0);
    run_frame('{}, 8'h00, 0);
    run_frame('{}, 8'h55, 0);

    run_frame('{8'h10, 8'h20, 8'h30}, 8'hAA, 1);
    run_frame('{8'h00}, 8'h0D, 1);
    run_frame('{}, 8'h00, 1);
    run_frame('{8'h01, 8'h02}, 8'hC7, 0);

    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(pl, ref_hash(pl), 0);
    pl.push_back(8'h55);
    run_frame(pl, ref_hash(pl), 0);

    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'(i * 7));
    run_frame(pl, ref_hash(pl), 0);
    pl.push_back(8'h99);
    run_frame(pl, ref_hash(pl), 0);
    pl = {};
    for (int i = 0; i < 300; i++) pl.push_back(8'($urandom));
    run_frame(pl, ref_hash(pl), 0);

    xfer(8'h12, 1'b0, st);
    xfer(8'h34, 1'b0, st);
    valid_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("abort_no_done", {done4, done64}, 2'b00);
    chk("abort_outs_clear", {h4, l4, m4, e4}, 18'd0);
    prev_h = 0; prev_l = 0; prev_m4 = 0; prev_e4 = 0; prev_m64 = 0; prev_e64 = 0;
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("abort_idle_no_done", {done4, done64, rdy4}, 3'b001);
    run_frame('{8'h00}, 8'h0D, 0);

    for (int f = 0; f < 40; f++) begin
      int len;
      len = (f % 8 == 7) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 7));
      rand_frame(len, (f != 39) && ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
